instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the byte-addressed instruction memory and feeds the decode stage. It owns the program counter and drives the memory address. It captures the returned 32-bit instruction word into an IF/ID register that uses a valid/ready handshake, and handles stalls, control-flow redirects/flushes and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 36, instruction memory size in bytes; a fetch is legal only if pc+4 <= IMEM_BYTES.
NOP_INSTR, 32'h0000_0013, value id_instr takes on reset (addi x0,x0,0).

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-low
imem_pc  out  32  byte address to instruction memory; combinational copy of the internal PC register
imem_instr  in  32  instruction word from memory, combinationally valid for imem_pc in the same cycle
redirect_valid  in  1  branch/jump taken from a later stage
redirect_pc  in  32  target address for the redirect
id_ready  in  1  decode can accept the IF/ID contents this cycle
id_valid  out  1  IF/ID register holds a valid instruction
id_instr  out  32  captured instruction
id_pc  out  32  address id_instr was fetched from
id_pc_plus4  out  32  id_pc + 4, mod 2^32
fetch_fault  out  1  sticky: misaligned or out-of-range fetch
fetch_count  out  32  number of completed handshakes (id_valid && id_ready)

Behaviour:
- Reset (reset==0 at posedge clk), with no other condition taking priority:
  - pc <= RESET_PC; state <= IDLE.
  - id_valid <= 0, id_instr <= NOP_INSTR, id_pc <= 0, id_pc_plus4 <= 0.
  - fetch_fault <= 0, fetch_count <= 0.
- Instruction memory contents are only written while reset is low. Fetch therefore never captures in the cycle immediately after reset releases.
- States:
  - IDLE: no capture; next state RUN unconditionally. imem_pc = pc.
  - RUN: normal fetch (rules below).
  - FAULT: id_valid = 0, fetch_fault = 1, pc held. Leaves only on redirect (-> RUN) or reset.
- load = (!id_valid || id_ready). Priority within RUN, evaluated at posedge:
  1. redirect_valid=1:
     - pc <= redirect_pc; id_valid <= 0 (flush); no capture this cycle.
     - Applies regardless of load, and also in IDLE and FAULT. In FAULT it also clears fetch_fault and moves to RUN.
  2. load=1 and (pc[1:0]!=0 or {1'b0,pc}+33'd4 > IMEM_BYTES):
     - state <= FAULT, fetch_fault <= 1, id_valid <= 0, pc unchanged.
  3. load=1, legal pc:
     - id_instr <= imem_instr, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1.
     - pc <= pc+4 (32-bit wrap).
  4. load=0 (stall): pc and the IF/ID register hold; imem_pc stable.
- Throughput: one instruction per cycle when id_ready is held high. Latency is 1 cycle from imem_pc to id_instr.
- fetch_count increments on every cycle where id_valid && id_ready before the edge. It is not affected by redirect in the same cycle and wraps at 2^32.
- A redirect in the same cycle as a handshake: the handshake counts and the new pc is loaded.
- A reset asserted mid-stall or while in FAULT: reset values apply on the next edge, overriding everything.

Test Plan:
1. Bench memory preloaded with 0x01498333, 0x40208433, 0x025303b3, 0x00210093 at byte addresses 0/4/8/12; release reset, id_ready=1.
   -> Cycle after release: id_valid=0. Then id_instr follows that sequence with id_pc=0,4,8,12 and id_pc_plus4=4,8,12,16; fetch_count reaches 4.
2. Stall: id_ready=0 for 3 cycles while id_valid=1 with id_pc=4.
   -> id_instr=0x40208433, id_pc=4 and imem_pc=8 stay constant; fetch_count unchanged. On id_ready=1, the next capture is pc 8.
3. Redirect during stall: redirect_valid=1, redirect_pc=0x0 while id_ready=0.
   -> Next cycle id_valid=0, imem_pc=0. The following cycle id_instr=0x01498333, id_pc=0.
4. IMEM_BYTES=16, run through address 12.
   -> Fetch at pc=16 sets fetch_fault=1, id_valid=0, pc stays 16. redirect_pc=0x4 clears the fault and the next capture is 0x40208433.
5. Misaligned redirect_pc=0x6.
   -> Next load cycle: fetch_fault=1, no capture, state FAULT.
6. reset=0 for one edge during a stall with id_valid=1.
   -> id_valid=0, id_instr=0x00000013, pc=0, fetch_count=0, fetch_fault=0. The first capture after release occurs two edges after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills the
// IF/ID register through a valid/ready handshake with decode.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 36,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        fetch_fault,
   output logic [31:0] fetch_count,
   output logic [1:0]  fsm_state
);

   // Handshake: an IF/ID entry moves to decode on a rising edge where
   // id_valid && id_ready; the register may be refilled whenever it is empty or
   // being drained in that same edge (load).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        valid_n;
   logic        fault_n;
   logic        capture;
   logic        load;
   logic        pc_illegal;

   assign imem_pc   = pc;
   assign fsm_state = state;
   assign load      = !id_valid || id_ready;
   assign pc_illegal = (pc[1:0] != 2'b00) || (({1'b0, pc} + 33'd4) > IMEM_LIMIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      valid_n = id_valid;
      fault_n = fetch_fault;
      capture = 1'b0;
      case (state)
         IDLE: begin
            // Memory is still being loaded on the first edge after reset.
            state_n = RUN;
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
            end else if (load) begin
               if (pc_illegal) begin
                  state_n = FAULT;
                  fault_n = 1'b1;
                  valid_n = 1'b0;
               end else begin
                  capture = 1'b1;
                  valid_n = 1'b1;
                  pc_n    = pc + 32'd4;
               end
            end
         end
         FAULT: begin
            valid_n = 1'b0;
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               fault_n = 1'b0;
               state_n = RUN;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= RESET_PC;
         id_valid    <= 1'b0;
         id_instr    <= NOP_INSTR;
         id_pc       <= 32'd0;
         id_pc_plus4 <= 32'd0;
         fetch_fault <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         pc          <= pc_n;
         id_valid    <= valid_n;
         fetch_fault <= fault_n;
         if (capture) begin
            id_instr    <= imem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
         end
         // Counted from the pre-edge handshake, independent of any redirect.
         if (id_valid && id_ready) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a cycle model predicts PC/state and
// pushes each expected capture into a queue that drains on every handshake.
module tb_instr_fetch_unit;

   localparam int unsigned IMEM = 16;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fetch_count;
   logic [1:0]  fsm_state;

   logic [31:0] mem [0:8];
   logic [95:0] exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic [31:0] m_pc;
   logic [1:0]  m_state;
   logic        m_valid;
   logic        m_fault;
   logic [31:0] m_count;

   instr_fetch_unit #(
      .RESET_PC  (32'h0),
      .IMEM_BYTES(IMEM),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_pc       (imem_pc),
      .imem_instr    (imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .id_ready      (id_ready),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_pc_plus4   (id_pc_plus4),
      .fetch_fault   (fetch_fault),
      .fetch_count   (fetch_count),
      .fsm_state     (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd36) return mem[a[5:2]];
      return 32'hdead_beef;
   endfunction

   assign imem_instr = mem_word(imem_pc);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_step();
      logic load;
      if (!reset) begin
         m_pc = 32'h0; m_state = 2'd0; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0;
         exp_q.delete();
      end else begin
         if (m_valid && id_ready) m_count = m_count + 32'd1;
         load = !m_valid || id_ready;
         if (redirect_valid) begin
            // an unaccepted entry is flushed
            if (m_valid && !id_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            m_pc = redirect_pc; m_valid = 1'b0; m_fault = 1'b0; m_state = 2'd1;
         end else if (m_state == 2'd0) begin
            m_state = 2'd1;
         end else if (m_state == 2'd1 && load) begin
            if (m_pc[1:0] != 2'b00 || ({1'b0, m_pc} + 33'd4) > 33'(IMEM)) begin
               m_state = 2'd2; m_fault = 1'b1; m_valid = 1'b0;
            end else begin
               exp_q.push_back({mem_word(m_pc), m_pc, m_pc + 32'd4});
               m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   // driver: one clock cycle with the given inputs
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst_n);
      logic [95:0] e;
      @(negedge clk);
      id_ready = rdy; redirect_valid = rv; redirect_pc = rpc; reset = rst_n;
      #1;
      if (reset && id_valid && id_ready) begin
         check("sb_underflow", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hs_instr", id_instr, e[95:64]);
            check("hs_pc", id_pc, e[63:32]);
            check("hs_pc4", id_pc_plus4, e[31:0]);
         end
      end
      @(posedge clk);
      model_step();
      #1;
      check("imem_pc", imem_pc, m_pc);
      check("id_valid", 32'(id_valid), 32'(m_valid));
      check("fault", 32'(fetch_fault), 32'(m_fault));
      check("count", fetch_count, m_count);
      check("state", 32'(fsm_state), 32'(m_state));
   endtask

   task automatic check_reset_values();
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_instr", id_instr, NOP);
      check("rst_pc", id_pc, 32'd0);
      check("rst_pc4", id_pc_plus4, 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_imem_pc", imem_pc, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sel;
      logic [31:0] tgt;
      logic [31:0] targets [0:6];
      mem[0] = 32'h0149_8333; mem[1] = 32'h4020_8433;
      mem[2] = 32'h0253_03b3; mem[3] = 32'h0021_0093;
      for (int i = 4; i < 9; i++) mem[i] = $urandom;
      targets[0] = 32'd0;  targets[1] = 32'd4;  targets[2] = 32'd8; targets[3] = 32'd12;
      targets[4] = 32'd16; targets[5] = 32'd6;  targets[6] = 32'd2;
      reset = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check_reset_values();

      // sequential fetch; runs off the end of the 16-byte memory
      cycle(1, 0, 0, 1);
      check("t1_first_valid", 32'(id_valid), 32'd0);
      cycle(1, 0, 0, 1);
      check("t1_instr0", id_instr, 32'h0149_8333);
      check("t1_pc4_0", id_pc_plus4, 32'd4);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
      check("t4_fault", 32'(fetch_fault), 32'd1);
      check("t1_count4", fetch_count, 32'd4);
      check("t4_pc_hold", imem_pc, 32'd16);
      cycle(1, 0, 0, 1);
      check("t4_pc_hold2", imem_pc, 32'd16);
      cycle(0, 1, 32'd4, 1);
      check("t4_fault_clr", 32'(fetch_fault), 32'd0);
      cycle(0, 0, 0, 1);
      check("t4_instr", id_instr, 32'h4020_8433);

      // stall with id_pc=4
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1);
         check("t2_pc", id_pc, 32'd4);
         check("t2_imem_pc", imem_pc, 32'd8);
         check("t2_count", fetch_count, 32'd4);
      end
      cycle(1, 0, 0, 1);
      check("t2_next_pc", id_pc, 32'd8);

      // redirect during stall
      cycle(0, 1, 32'd0, 1);
      check("t3_flush", 32'(id_valid), 32'd0);
      check("t3_imem_pc", imem_pc, 32'd0);
      cycle(1, 0, 0, 1);
      check("t3_instr", id_instr, 32'h0149_8333);
      check("t3_pc", id_pc, 32'd0);

      // misaligned redirect
      cycle(1, 1, 32'd6, 1);
      cycle(1, 0, 0, 1);
      check("t5_fault", 32'(fetch_fault), 32'd1);
      check("t5_state", 32'(fsm_state), 32'd2);

      // reset during a stall with a valid entry
      cycle(1, 1, 32'd8, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      check("t6_valid_pre", 32'(id_valid), 32'd1);
      cycle(0, 0, 0, 0);
      check_reset_values();
      cycle(1, 0, 0, 1);
      check("t6_edge1", 32'(id_valid), 32'd0);
      cycle(1, 0, 0, 1);
      check("t6_edge2", 32'(id_valid), 32'd1);
      check("t6_pc", id_pc, 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 6);
         tgt = targets[sel];
         cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) == 0), tgt,
               logic'($urandom_range(0, 99) != 0));
      end
      cycle(1, 0, 0, 1);
      check("sb_pending", 32'(exp_q.size()), 32'(m_valid));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
